seg_digit_scheduler: RTL and testbench

Time-multiplexing scheduler for the multi-digit seven-segment display. Steps through the digit positions with a fixed dwell time and a dead-time blanking gap, driving the digit transistor enables and the shared 4-bit hex code bus. The digit values are double-buffered behind a valid/ready load handshake, so a new value set only takes effect at a frame boundary. Sits between the value producers (switch inputs, adder, counters) and the shared seven-segment decoder.

---
 rtl/seg_digit_scheduler_if.sv | 35 +++
 rtl/seg_digit_scheduler.sv | 145 ++++++++++++++
 tb/tb_seg_digit_scheduler.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/seg_digit_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg_digit_scheduler_if
//  Description : Load handshake and display bus between the value producers,
//                the digit scheduler and the shared seven-segment decoder.
//                  digits_in   : candidate digit codes, digit i at [4i+3:4i]
//                  load_valid  : producer offers a value set
//                  load_ready  : scheduler can accept a value set
//                  sout        : hex code for the current/next digit
//                  digit_en    : one-hot digit transistor enables
//                  frame_start : pulse on first ON cycle of digit 0
//                master modport = producer/display side, slave = scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seg_digit_scheduler_if #(
  parameter int NDIG = 2
);
  logic [4*NDIG-1:0] digits_in;
  logic              load_valid;
  logic              load_ready;
  logic [3:0]        sout;
  logic [NDIG-1:0]   digit_en;
  logic              frame_start;

  modport master (
    output digits_in, load_valid,
    input  load_ready, sout, digit_en, frame_start
  );

  modport slave (
    input  digits_in, load_valid,
    output load_ready, sout, digit_en, frame_start
  );
endinterface
`default_nettype wire

// File: rtl/seg_digit_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : seg_digit_scheduler
//  Description : Time-multiplexing scheduler for a multi-digit seven-segment
//                display. Each digit is enabled for DWELL_CYC clocks, preceded
//                by BLANK_CYC clocks of all-off dead time. Digit values are
//                double-buffered (pend -> active) and swapped only at the end
//                of the last digit's ON phase (frame boundary).
//  Ports       : clk   - system clock
//                reset - asynchronous, active-high reset
//                bus   - seg_digit_scheduler_if.slave (load handshake in,
//                        sout / digit_en / frame_start out)
//  Config      : SEG_DEADTIME_EN defined   -> BLANK phase before every digit.
//                SEG_DEADTIME_EN undefined -> digits switch back to back; a
//                single all-off cycle follows reset only.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_digit_scheduler #(
  parameter int NDIG      = 2,
  parameter int DWELL_CYC = 8192,
  parameter int BLANK_CYC = 256
) (
  input  wire logic             clk,
  input  wire logic             reset,
  seg_digit_scheduler_if.slave  bus
);

  // Counter sized for the longer of the two phases in either build.
  localparam int c_cnt_max = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
  localparam int c_idx_w   = $clog2(NDIG);

`ifdef SEG_DEADTIME_EN
  localparam int c_blank_len = BLANK_CYC;
`else
  // Without dead time the blank state only serves as the one-cycle
  // all-off startup after reset and is never re-entered.
  localparam int c_blank_len = 1;
`endif

  localparam logic [c_cnt_w-1:0] c_blank_last = c_cnt_w'(c_blank_len - 1);
  localparam logic [c_cnt_w-1:0] c_dwell_last = c_cnt_w'(DWELL_CYC - 1);
  localparam logic [c_idx_w-1:0] c_idx_last   = c_idx_w'(NDIG - 1);
  localparam logic [NDIG-1:0]    c_one_hot0   = NDIG'(1);

  typedef enum logic [0:0] {
    S_BLANK = 1'b0,
    S_ON    = 1'b1
  } state_t;

  state_t              r_state,  w_state_nxt;
  logic [c_cnt_w-1:0]  r_cnt,    w_cnt_nxt;
  logic [c_idx_w-1:0]  r_idx,    w_idx_nxt;
  logic [4*NDIG-1:0]   r_active, w_active_nxt;
  logic [4*NDIG-1:0]   r_pend;
  logic                r_pend_full;
  logic [3:0]          r_sout,   w_sout_nxt;
  logic [NDIG-1:0]     r_digit_en, w_digit_en_nxt;
  logic                r_frame_start, w_frame_start_nxt;
  logic                w_boundary;
  logic                w_accept;

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt + 1'b1;
    w_idx_nxt         = r_idx;
    w_boundary        = 1'b0;
    w_frame_start_nxt = 1'b0;

    case (r_state)
      S_BLANK: begin
        if (r_cnt == c_blank_last) begin
          w_state_nxt       = S_ON;
          w_cnt_nxt         = '0;
          w_frame_start_nxt = (r_idx == '0);
        end
      end
      S_ON: begin
        if (r_cnt == c_dwell_last) begin
          w_cnt_nxt  = '0;
          w_boundary = (r_idx == c_idx_last);
          w_idx_nxt  = w_boundary ? '0 : r_idx + 1'b1;
`ifdef SEG_DEADTIME_EN
          w_state_nxt = S_BLANK;
`else
          // Straight into ON of the next digit; wrapping to digit 0 is
          // the start of a new frame.
          w_frame_start_nxt = w_boundary;
`endif
        end
      end
      default: begin
        w_state_nxt = S_BLANK;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
      end
    endcase

    w_accept     = bus.load_valid && !r_pend_full;
    // Only a value pending before the boundary cycle is promoted; one
    // accepted on the boundary itself waits for the next frame.
    w_active_nxt = (w_boundary && r_pend_full) ? r_pend : r_active;
    // Outputs are registered from next-state values so that they line up
    // with the state they describe; sout moves only with an idx change.
    w_sout_nxt     = w_active_nxt[{w_idx_nxt, 2'b00} +: 4];
    w_digit_en_nxt = (w_state_nxt == S_ON) ? (c_one_hot0 << w_idx_nxt) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_BLANK;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_active      <= '0;
      r_pend        <= '0;
      r_pend_full   <= 1'b0;
      r_sout        <= '0;
      r_digit_en    <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_idx         <= w_idx_nxt;
      r_active      <= w_active_nxt;
      r_sout        <= w_sout_nxt;
      r_digit_en    <= w_digit_en_nxt;
      r_frame_start <= w_frame_start_nxt;
      // Accept and promotion are mutually exclusive: accept needs the
      // pending buffer empty, promotion needs it full.
      if (w_accept) begin
        r_pend      <= bus.digits_in;
        r_pend_full <= 1'b1;
      end else if (w_boundary && r_pend_full) begin
        r_pend_full <= 1'b0;
      end
    end
  end

  assign bus.load_ready  = ~r_pend_full;
  assign bus.sout        = r_sout;
  assign bus.digit_en    = r_digit_en;
  assign bus.frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_seg_digit_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_digit_scheduler
//  Description : Self-checking bench for seg_digit_scheduler. Random producer
//                traffic is checked cycle by cycle against a model that
//                derives the display position from elapsed time since reset
//                and the shown value set from the frame each load lands in.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_digit_scheduler;

  localparam int NDIG      = 2;
  localparam int DWELL_CYC = 4;
  localparam int BLANK_CYC = 2;
  localparam int W         = 4 * NDIG;

`ifdef SEG_DEADTIME_EN
  localparam bit DEADTIME = 1'b1;
  localparam int FRAME    = NDIG * (DWELL_CYC + BLANK_CYC);
`else
  localparam bit DEADTIME = 1'b0;
  localparam int FRAME    = NDIG * DWELL_CYC;
`endif

  logic clk;
  logic reset;

  seg_digit_scheduler_if #(.NDIG(NDIG)) bus ();

  seg_digit_scheduler #(
    .NDIG      (NDIG),
    .DWELL_CYC (DWELL_CYC),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int t       = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (t=%0d) got=%0h expected=%0h", tag, t, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int           act_frame;
    logic [W-1:0] val;
  } load_t;

  load_t loads[$];

  function automatic int frame_of(input int tt);
    if (DEADTIME) return tt / FRAME;
    return (tt == 0) ? 0 : (tt - 1) / FRAME;
  endfunction

  function automatic bit ready_m(input int tt);
    foreach (loads[i])
      if (loads[i].act_frame > frame_of(tt)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [W-1:0] active_for(input int fr);
    logic [W-1:0] v = '0;
    foreach (loads[i])
      if (loads[i].act_frame <= fr) v = loads[i].val;
    return v;
  endfunction

  logic [NDIG-1:0] exp_en;
  logic [3:0]      exp_sout;
  logic            exp_fs;

  task automatic model_outputs(input int tt);
    int f, d, p, u;
    logic [W-1:0] a;
    if (DEADTIME) begin
      f        = tt % FRAME;
      d        = f / (DWELL_CYC + BLANK_CYC);
      p        = f % (DWELL_CYC + BLANK_CYC);
      exp_en   = (p >= BLANK_CYC) ? NDIG'(1 << d) : '0;
      exp_fs   = (f == BLANK_CYC);
      a        = active_for(tt / FRAME);
      exp_sout = 4'((a >> (4 * d)) & 'hF);
    end else if (tt == 0) begin
      exp_en   = '0;
      exp_fs   = 1'b0;
      exp_sout = 4'((active_for(0)) & 'hF);
    end else begin
      u        = tt - 1;
      f        = u % FRAME;
      d        = f / DWELL_CYC;
      exp_en   = NDIG'(1 << d);
      exp_fs   = (f == 0);
      a        = active_for(u / FRAME);
      exp_sout = 4'((a >> (4 * d)) & 'hF);
    end
  endtask

  task automatic check_now();
    model_outputs(t);
    check("digit_en",    32'(bus.digit_en),    32'(exp_en));
    check("sout",        32'(bus.sout),        32'(exp_sout));
    check("frame_start", 32'(bus.frame_start), 32'(exp_fs));
    check("load_ready",  32'(bus.load_ready),  32'(ready_m(t)));
  endtask

  // ---------------- producer ----------------
  bit hold;

  // Drive this cycle's request, record any accept, move to the next cycle.
  task automatic advance(input bit force_valid);
    if (!hold) begin
      bus.load_valid = force_valid || ($urandom_range(0, 3) == 0);
      bus.digits_in  = W'($urandom);
    end
    if (bus.load_valid && ready_m(t)) begin
      loads.push_back('{act_frame: frame_of(t + 1) + 1, val: bus.digits_in});
      hold = 1'b0;
    end else begin
      hold = bus.load_valid;
    end
    @(negedge clk);
    #1;
    t++;
  endtask

  task automatic release_reset();
    loads.delete();
    hold           = 1'b0;
    bus.load_valid = 1'b0;
    reset          = 1'b0;
    t              = 0;
  endtask

  bit found;

  initial begin
    reset          = 1'b1;
    hold           = 1'b0;
    bus.load_valid = 1'b0;
    bus.digits_in  = '0;

    // Reset hold: outputs stay at reset values whatever the producer does.
    repeat (4) begin
      @(negedge clk);
      #1;
      bus.load_valid = 1'(($urandom_range(0, 1)));
      bus.digits_in  = W'($urandom);
      check("rst_digit_en",    32'(bus.digit_en),    32'h0);
      check("rst_sout",        32'(bus.sout),        32'h0);
      check("rst_frame_start", 32'(bus.frame_start), 32'h0);
      check("rst_load_ready",  32'(bus.load_ready),  32'h1);
    end

    @(negedge clk);
    #1;
    release_reset();

    repeat (300) begin
      check_now();
      advance(1'b0);
    end

    // Steer to a cycle with the last digit ON and a value still pending.
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      model_outputs(t);
      if (exp_en == NDIG'(1 << (NDIG - 1)) && !ready_m(t)) begin
        found = 1'b1;
        break;
      end
      check_now();
      advance(1'b1);
    end
    check("reach_mid_on_pending", 32'(found), 32'h1);
    check_now();

    // Asynchronous reset in the middle of the clock period.
    #2;
    reset = 1'b1;
    #1;
    check("async_digit_en",    32'(bus.digit_en),    32'h0);
    check("async_load_ready",  32'(bus.load_ready),  32'h1);
    check("async_sout",        32'(bus.sout),        32'h0);
    check("async_frame_start", 32'(bus.frame_start), 32'h0);
    bus.load_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    release_reset();

    repeat (250) begin
      check_now();
      advance(1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
